// File: rtl/mips150_pkg.sv
// Shared MIPS150 muldiv definitions: op encodings, FSM states, funct decode.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package mips150_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Control-side view of one R-type funct code touching HI/LO.
  typedef struct packed {
    logic       start;
    logic [1:0] op;
    logic       mfhi;
    logic       mthi;
    logic       mflo;
    logic       mtlo;
  } md_ctrl_t;

  // 0x18..0x1B start MULT/MULTU/DIV/DIVU (op = funct[1:0]);
  // 0x10..0x13 are MFHI/MTHI/MFLO/MTLO.
  function automatic md_ctrl_t decode_funct(input logic [5:0] funct);
    md_ctrl_t c;
    c = '0;
    if (funct[5:2] == 4'b0110) begin
      c.start = 1'b1;
      c.op    = funct[1:0];
    end else if (funct[5:2] == 4'b0100) begin
      case (funct[1:0])
        2'd0:    c.mfhi = 1'b1;
        2'd1:    c.mthi = 1'b1;
        2'd2:    c.mflo = 1'b1;
        default: c.mtlo = 1'b1;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/mips150_muldiv_if.sv
// Request/result bundle between the control/datapath and the muldiv unit.
// Latency: n/a (wires only).
// Backpressure: requester must hold off start/MT* while busy is high.
interface mips150_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mips150_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Latency: fixed WIDTH+2 cycles from accepted start to done, for every op/operand.
// Backpressure: start and MTHI/MTLO are ignored while busy; no queueing.
module mips150_muldiv
  import mips150_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  mips150_muldiv_if.slave md
);

  localparam int CW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_mul_q, is_mul_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               start_mul, sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   sub_res;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand conditioning: signed ops work on magnitudes, signs re-applied in FIX.
  always_comb begin
    start_mul = (md.op == OP_MULT) || (md.op == OP_MULTU);
    sgn_op    = (md.op == OP_MULT) || (md.op == OP_DIV);
    a_neg     = sgn_op & md.a[WIDTH-1];
    b_neg     = sgn_op & md.b[WIDTH-1];
    a_mag     = a_neg ? -md.a : md.a;
    b_mag     = b_neg ? -md.b : md.b;
  end

  // Per-iteration arithmetic plus the final sign correction of the accumulator.
  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
  always_comb begin
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    shifted  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    sub_res  = {1'b0, shifted} - {2'b00, opnd_q};
    prod_fix = qneg_q ? -acc_q : acc_q;
    quo_fix  = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state, iteration step and HI/LO write selection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_mul_d = is_mul_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (md.mthi) hi_d = md.wdata;
        if (md.mtlo) lo_d = md.wdata;
        if (md.start) begin
          state_d  = ST_CALC;
          cnt_d    = '0;
          is_mul_d = start_mul;
          // Divide by zero keeps the quotient positive so LO ends up all ones;
          // the remainder then naturally reconstructs the dividend.
          qneg_d   = (a_neg ^ b_neg) & ~(~start_mul & (md.b == '0));
          rneg_d   = a_neg;
          opnd_d   = start_mul ? a_mag : b_mag;
          acc_d    = {{WIDTH{1'b0}}, (start_mul ? b_mag : a_mag)};
        end
      end
      ST_CALC: begin
        if (is_mul_q) begin
          acc_d = {add_sum, acc_q[WIDTH-1:1]};
        end else if (!sub_res[WIDTH+1]) begin
          acc_d = {sub_res[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (is_mul_q) begin
          {hi_d, lo_d} = prod_fix;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and architectural registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_mul_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_mul_q <= is_mul_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_mips150_muldiv.sv
// Scoreboard bench for mips150_muldiv: native-operator reference results queued
// at issue and popped at done; latency, handshake, MT* and reset scenarios.
module tb_mips150_muldiv;
  import mips150_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips150_muldiv_if #(.WIDTH(W)) md ();
  mips150_muldiv #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .md(md));

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  res_t sbq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    logic signed [W-1:0]   sa, sb;
    logic signed [2*W-1:0] sp;
    logic [2*W-1:0]        up;
    sa = a;
    sb = b;
    r  = '0;
    case (op)
      OP_MULT: begin
        sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        {r.hi, r.lo} = sp;
      end
      OP_MULTU: begin
        up = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        {r.hi, r.lo} = up;
      end
      OP_DIV: begin
        if (b == '0) begin
          r.hi = a; r.lo = '1;
        end else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
          r.hi = '0; r.lo = a;
        end else begin
          r.lo = sa / sb; r.hi = sa % sb;
        end
      end
      default: begin
        if (b == '0) begin
          r.hi = a; r.lo = '1;
        end else begin
          r.lo = a / b; r.hi = a % b;
        end
      end
    endcase
    return r;
  endfunction

  // Called #1 after an edge with the unit idle; returns #1 into cycle t+1.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    md.start = 1'b1;
    md.op    = op;
    md.a     = a;
    md.b     = b;
    sbq.push_back(model(op, a, b));
    tick();
    md.start = 1'b0;
  endtask

  // k counts cycles after the accepting edge; bounded so a dead DUT still ends.
  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (md.done !== 1'b1 && k < 80) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    checks++; if (md.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", md.busy); end
    checks++; if (md.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", md.done); end
    checks++; if (md.hi !== '0) begin failures++; $display("FAIL reset_hi got=%h want=0", md.hi); end
    checks++; if (md.lo !== '0) begin failures++; $display("FAIL reset_lo got=%h want=0", md.lo); end
  endtask

  task automatic test_mult_latency();
    int busy_cnt, done_at, pulses;
    res_t e;
    busy_cnt = 0; done_at = 0; pulses = 0;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    for (int i = 1; i <= 45; i++) begin
      if (md.busy === 1'b1) busy_cnt++;
      if (md.done === 1'b1) begin
        pulses++;
        if (done_at == 0) done_at = i;
        checks++; if (md.busy !== 1'b0) begin failures++; $display("FAIL lat_busy_at_done got=%b want=0", md.busy); end
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          checks++; if (md.hi !== e.hi) begin failures++; $display("FAIL lat_hi got=%h want=%h", md.hi, e.hi); end
          checks++; if (md.lo !== e.lo) begin failures++; $display("FAIL lat_lo got=%h want=%h", md.lo, e.lo); end
        end
      end
      tick();
    end
    checks++; if (done_at !== LAT) begin failures++; $display("FAIL lat_done_cycle got=%0d want=%0d", done_at, LAT); end
    checks++; if (busy_cnt !== W + 1) begin failures++; $display("FAIL lat_busy_cycles got=%0d want=%0d", busy_cnt, W + 1); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL lat_done_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_patterns();
    logic [1:0]   ops[8] = '{OP_MULTU, OP_DIV, OP_DIV, OP_DIV, OP_MULT, OP_DIV, OP_DIVU, OP_DIVU};
    logic [W-1:0] as[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFB,
                             32'h8000_0000, 32'd7, 32'hFFFF_FFFF, 32'd5};
    logic [W-1:0] bs[8]  = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd0,
                             32'h8000_0000, 32'hFFFF_FFFE, 32'd3, 32'd9};
    logic [1:0]   op;
    logic [W-1:0] a, b;
    int k;
    res_t e;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) begin
        op = ops[i]; a = as[i]; b = bs[i];
      end else begin
        op = 2'($urandom_range(0, 3));
        a  = $urandom();
        b  = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom();
      end
      issue(op, a, b);
      wait_done(1, k);
      checks++; if (k !== LAT) begin failures++; $display("FAIL pat%0d_latency got=%0d want=%0d", i, k, LAT); end
      e = sbq.pop_front();
      checks++; if (md.hi !== e.hi) begin failures++; $display("FAIL pat%0d_hi op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, md.hi, e.hi); end
      checks++; if (md.lo !== e.lo) begin failures++; $display("FAIL pat%0d_lo op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, md.lo, e.lo); end
      tick();
    end
  endtask

  task automatic test_divzero_ignore();
    int pulses, done_at;
    res_t e;
    pulses = 0; done_at = 0;
    issue(OP_DIVU, 32'd100, 32'd0);
    for (int i = 1; i <= 70; i++) begin
      if (md.done === 1'b1) begin
        pulses++;
        if (done_at == 0) begin
          done_at = i;
          e = sbq.pop_front();
          checks++; if (md.hi !== e.hi) begin failures++; $display("FAIL dz_hi got=%h want=%h", md.hi, e.hi); end
          checks++; if (md.lo !== e.lo) begin failures++; $display("FAIL dz_lo got=%h want=%h", md.lo, e.lo); end
        end
      end
      md.start = (i == 10);
      md.op    = OP_MULTU;
      md.a     = 32'd5;
      md.b     = 32'd5;
      tick();
    end
    md.start = 1'b0;
    checks++; if (done_at !== LAT) begin failures++; $display("FAIL dz_done_cycle got=%0d want=%0d", done_at, LAT); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL dz_done_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_mt();
    int k;
    res_t e;
    md.mthi = 1'b1; md.wdata = 32'h0000_1234;
    tick();
    md.mthi = 1'b0;
    checks++; if (md.hi !== 32'h0000_1234) begin failures++; $display("FAIL mthi_idle got=%h want=00001234", md.hi); end
    md.mtlo = 1'b1; md.wdata = 32'h0000_5678;
    tick();
    md.mtlo = 1'b0;
    checks++; if (md.lo !== 32'h0000_5678) begin failures++; $display("FAIL mtlo_idle got=%h want=00005678", md.lo); end
    checks++; if (md.hi !== 32'h0000_1234) begin failures++; $display("FAIL mtlo_keeps_hi got=%h want=00001234", md.hi); end
    // MTLO together with start: both take effect.
    md.mtlo = 1'b1; md.wdata = 32'h0000_CAFE;
    issue(OP_MULTU, 32'd6, 32'd7);
    md.mtlo = 1'b0;
    checks++; if (md.lo !== 32'h0000_CAFE) begin failures++; $display("FAIL mtlo_with_start got=%h want=0000cafe", md.lo); end
    checks++; if (md.busy !== 1'b1) begin failures++; $display("FAIL start_with_mtlo_busy got=%b want=1", md.busy); end
    // MTHI held throughout the op must not touch HI.
    md.mthi = 1'b1; md.wdata = 32'hDEAD_BEEF;
    repeat (5) tick();
    checks++; if (md.hi !== 32'h0000_1234) begin failures++; $display("FAIL mthi_busy_ignored got=%h want=00001234", md.hi); end
    wait_done(6, k);
    md.mthi = 1'b0;
    checks++; if (k !== LAT) begin failures++; $display("FAIL mt_op_latency got=%0d want=%0d", k, LAT); end
    e = sbq.pop_front();
    checks++; if (md.hi !== e.hi) begin failures++; $display("FAIL mt_op_hi got=%h want=%h", md.hi, e.hi); end
    checks++; if (md.lo !== e.lo) begin failures++; $display("FAIL mt_op_lo got=%h want=%h", md.lo, e.lo); end
    tick();
  endtask

  task automatic test_back_to_back();
    int k;
    res_t e;
    issue(OP_MULT, 32'hFFFF_0010, 32'h0000_0123);
    wait_done(1, k);
    checks++; if (k !== LAT) begin failures++; $display("FAIL b2b_first_latency got=%0d want=%0d", k, LAT); end
    e = sbq.pop_front();
    checks++; if ({md.hi, md.lo} !== {e.hi, e.lo}) begin failures++; $display("FAIL b2b_first_result got=%h_%h want=%h_%h", md.hi, md.lo, e.hi, e.lo); end
    // Start in the done cycle itself.
    issue(OP_DIVU, 32'd1000, 32'd7);
    wait_done(1, k);
    checks++; if (k !== LAT) begin failures++; $display("FAIL b2b_second_latency got=%0d want=%0d", k, LAT); end
    e = sbq.pop_front();
    checks++; if (md.hi !== e.hi) begin failures++; $display("FAIL b2b_second_hi got=%h want=%h", md.hi, e.hi); end
    checks++; if (md.lo !== e.lo) begin failures++; $display("FAIL b2b_second_lo got=%h want=%h", md.lo, e.lo); end
    tick();
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    issue(OP_MULTU, 32'd3, 32'd5);
    void'(sbq.pop_back());
    repeat (9) tick();
    #2;
    rst = 1'b0;
    #1;
    checks++; if (md.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", md.busy); end
    checks++; if (md.done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b want=0", md.done); end
    checks++; if (md.hi !== '0) begin failures++; $display("FAIL rstmid_hi got=%h want=0", md.hi); end
    checks++; if (md.lo !== '0) begin failures++; $display("FAIL rstmid_lo got=%h want=0", md.lo); end
    repeat (2) tick();
    rst = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (md.done === 1'b1) pulses++;
      tick();
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL rstmid_no_done got=%0d want=0", pulses); end
    checks++; if (md.busy !== 1'b0) begin failures++; $display("FAIL rstmid_idle_busy got=%b want=0", md.busy); end
  endtask

  initial begin
    md.start = 1'b0;
    md.op    = OP_MULT;
    md.a     = '0;
    md.b     = '0;
    md.mthi  = 1'b0;
    md.mtlo  = 1'b0;
    md.wdata = '0;
    rst      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b1;
    tick();
    test_mult_latency();
    test_patterns();
    test_divzero_ignore();
    test_mt();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips150_muldiv.md
# mips150_muldiv

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the MIPS150 core. It executes MULT, MULTU, DIV and DIVU over a configurable operand width. It presents a busy/done handshake that the control unit uses to stall MFHI/MFLO and new muldiv ops. The block sits beside the ALU in the datapath and is the core's only multi-cycle functional unit.

## Interface
- WIDTH, 32: operand width, and width of each of HI and LO; even, ≥4.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled only when busy=0.
- op  in  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- a  in  WIDTH  rs operand (multiplicand / dividend); captured on accepted start.
- b  in  WIDTH  rt operand (multiplier / divisor); captured on accepted start.
- mthi  in  1  write `wdata` into HI (MTHI).
- mtlo  in  1  write `wdata` into LO (MTLO).
- wdata  in  WIDTH  data for MTHI/MTLO.
- busy  out  1  operation in flight; the control unit stalls on MFHI/MFLO/MT*/start while this is high.
- done  out  1  one-cycle pulse: HI/LO have just been updated by a completed op.
- hi  out  WIDTH  HI register (upper product half / remainder).
- lo  out  WIDTH  LO register (lower product half / quotient).

## Operation
- FSM states:
  - IDLE → CALC on `start`.
  - CALC runs WIDTH iterations, then → FIX.
  - FIX → IDLE.
- IDLE:
  - `start` captures op and the magnitudes of a and b; signed ops use two's-complement abs.
  - Captures the result sign: product sign is a[MSB]^b[MSB]; quotient sign is the same; remainder sign is a[MSB].
  - Clears the iteration counter.
- CALC, multiply: shift-add on a 2·WIDTH accumulator, one multiplier bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle, with a WIDTH+1-bit partial remainder.
- FIX:
  - Applies sign correction.
  - Writes {HI,LO} = product, or HI = remainder and LO = quotient.
  - Asserts done for exactly that cycle.
- Signed division truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero, signed or unsigned: LO = all ones, HI = a. The op still takes full latency.
- Overflow, most-negative / −1: LO = most-negative, HI = 0 (the natural wrap result).
- Multiply results are exact 2·WIDTH-bit products; there is no overflow.
- MTHI/MTLO:
  - Act only when busy=0; they update the named register on the next edge.
  - Asserted while busy, they are ignored.
  - If asserted with `start` in the same IDLE cycle, the MT* write happens and start is accepted.
- `start` while busy=1 is ignored; there is no queueing.
- Only a completed FIX or an MT* write changes HI and LO. During CALC they hold their previous values.

## Timing
- Reset (rst=0, asynchronous): FSM=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal accumulators=0.
- Reset mid-operation aborts the op with no HI/LO update, and no done after release.
- With start accepted at edge t:
  - busy=1 during cycles t+1 … t+WIDTH+1.
  - done=1 and new HI/LO visible in cycle t+WIDTH+2, with busy=0 in that cycle.
- Total latency is WIDTH+2 cycles for every op and every operand value; there is no early-out.
- A new start is accepted in the done cycle, giving back-to-back ops every WIDTH+2 cycles.
- busy, done, hi and lo are all registered outputs; there are no combinational input-to-output paths.

## Structure
- Shared package `mips150_pkg`:
  - op encoding localparams: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - FSM state typedef/localparams.
  - Control-side decode of funct codes 0x18–0x1B and 0x10–0x13.
- No sub-module is required. An optional `mips150_muldiv_iter` may hold the per-cycle shift-add/subtract step if both the multiply and divide paths share one WIDTH+1 adder.
- Instantiated in the MIPS150 datapath. busy feeds the control unit's stall logic.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=7 → done at t+34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=100, b=0 → lo=0xFFFFFFFF, hi=100 after full 34-cycle latency; second start issued mid-op is ignored, giving one done pulse.
- MTHI 0x1234 then MTLO 0x5678 while idle → hi/lo update next edge. mthi asserted while busy → hi unchanged until FIX.
- Start MULTU, drop rst at cycle t+10 → busy/done/hi/lo=0 immediately. After release with no start → no done pulse ever.
